// File: rtl/core_bus_arb.sv
// core_bus_arb: two-master to one-slave command arbiter with in-order read-response routing.
module core_bus_arb #(
   parameter int MAX_PEND = 4,
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rest,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid,
   output logic        err_unexp
);
   localparam int AW = $clog2(MAX_PEND);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(MAX_PEND);
   typedef enum logic {OPEN, LOCKED} state_t;
   state_t state, state_nx;
   logic owner, last_acc;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic fifo_id [MAX_PEND];
   logic full, m0_ok, m1_ok, lock_hold, gnt_v, gnt, cmd, acc, push, pop;
   always_comb begin
      full = count == FULL_CNT;
      // a read is only eligible while the response FIFO has room; writes always are
      m0_ok = ~rest & (m0_write | (m0_read & ~full));
      m1_ok = ~rest & (m1_write | (m1_read & ~full));
      lock_hold = (state == LOCKED) & (owner ? m1_ok : m0_ok);
      gnt_v = m0_ok | m1_ok;
      gnt = lock_hold ? owner : (m0_ok & m1_ok) ? (RR_EN ? ~last_acc : 1'b1) : m1_ok;
      s_read = gnt_v & (gnt ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
      s_write = gnt_v & (gnt ? m1_write : m0_write);
      s_address = gnt_v ? (gnt ? m1_address : m0_address) : '0;
      s_writedata = gnt_v ? (gnt ? m1_writedata : m0_writedata) : '0;
      s_byteenable = gnt_v ? (gnt ? m1_byteenable : m0_byteenable) : '0;
      m0_waitrequest = (gnt_v & ~gnt) ? s_waitrequest : 1'b1;
      m1_waitrequest = (gnt_v & gnt) ? s_waitrequest : 1'b1;
      cmd = s_read | s_write;
      acc = cmd & ~s_waitrequest;
      push = acc & s_read;
      pop = s_readdatavalid & (count != '0);
      state_nx = (cmd & s_waitrequest) ? LOCKED : OPEN;
      m0_readdata = s_readdata;
      m1_readdata = s_readdata;
      m0_readdatavalid = pop & ~fifo_id[rptr];
      m1_readdatavalid = pop & fifo_id[rptr];
      err_unexp = ~rest & s_readdatavalid & (count == '0);
   end
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state <= OPEN;
         owner <= 1'b0;
         last_acc <= 1'b1;
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         owner <= gnt;
         if (acc) last_acc <= gnt;
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) fifo_id[wptr] <= gnt;
   end
endmodule

// File: tb/tb_core_bus_arb.sv
// tb_core_bus_arb: directed tests for core_bus_arb with default parameters.
module tb_core_bus_arb;
   logic clk, rest;
   logic [31:0] m0_address, m0_writedata, m0_readdata, m1_address, m1_writedata, m1_readdata;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic [3:0] m0_byteenable, m1_byteenable, s_byteenable;
   logic m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
   logic m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
   logic s_read, s_write, s_waitrequest, s_readdatavalid, err_unexp;
   int n_cmp, n_err;

   core_bus_arb dut (
      .clk(clk), .rest(rest),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .err_unexp(err_unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rest = 1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      m0_read = 1; m1_write = 1; s_readdatavalid = 1;
      #1;
      n_cmp++; if (s_read !== 1'b0 || s_write !== 1'b0) begin n_err++; $display("FAIL reset_cmd: got rd=%b wr=%b want 0 0", s_read, s_write); end
      n_cmp++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait: got %b %b want 1 1", m0_waitrequest, m1_waitrequest); end
      n_cmp++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || err_unexp !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got rdv=%b%b err=%b want 00 0", m0_readdatavalid, m1_readdatavalid, err_unexp); end
      idle();
      next();
      rest = 0;
      m0_address = 32'h123; m0_writedata = 32'h55; m0_byteenable = 4'hF;
      #1;
      n_cmp++; if (s_address !== 32'h0 || s_writedata !== 32'h0 || s_byteenable !== 4'h0 || s_read !== 1'b0) begin n_err++; $display("FAIL idle_bus: got a=%h d=%h be=%h rd=%b want 0", s_address, s_writedata, s_byteenable, s_read); end
      idle();
      next();
   endtask

   task automatic test_round_robin();
      m0_address = 32'h200; m1_address = 32'h300;
      for (int i = 0; i < 5; i++) begin
         m0_read = (i < 4); m1_read = (i < 4);
         s_readdatavalid = (i > 0); s_readdata = 32'(i);
         #1;
         if (i < 4) begin
            n_cmp++; if (s_address !== ((i % 2) ? 32'h300 : 32'h200) || s_read !== 1'b1) begin n_err++; $display("FAIL rr_grant%0d: got a=%h rd=%b want %h 1", i, s_address, s_read, (i % 2) ? 32'h300 : 32'h200); end
         end
         if (i > 0) begin
            n_cmp++; if (m0_readdatavalid !== ((i - 1) % 2 == 0) || m1_readdatavalid !== ((i - 1) % 2 == 1)) begin n_err++; $display("FAIL rr_route%0d: got rdv=%b%b want m%0d", i, m1_readdatavalid, m0_readdatavalid, (i - 1) % 2); end
         end
         next();
      end
      idle();
   endtask

   task automatic test_lock();
      m0_address = 32'h600; m1_address = 32'h400; m1_writedata = 32'hCAFE; m1_byteenable = 4'h3;
      for (int c = 1; c <= 4; c++) begin
         m1_write = 1; m0_read = (c > 1); s_waitrequest = (c < 4);
         #1;
         n_cmp++; if (s_write !== 1'b1 || s_address !== 32'h400 || s_writedata !== 32'hCAFE || s_byteenable !== 4'h3) begin n_err++; $display("FAIL lock_own%0d: got wr=%b a=%h d=%h be=%h want 1 400 cafe 3", c, s_write, s_address, s_writedata, s_byteenable); end
         n_cmp++; if (m1_waitrequest !== (c < 4) || m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL lock_wait%0d: got m1=%b m0=%b want %b 1", c, m1_waitrequest, m0_waitrequest, c < 4); end
         next();
      end
      s_waitrequest = 0;
      #1;
      n_cmp++; if (s_read !== 1'b1 || s_address !== 32'h600 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL lock_release: got rd=%b a=%h w0=%b w1=%b want 1 600 0 1", s_read, s_address, m0_waitrequest, m1_waitrequest); end
      next();
      idle();
      s_readdatavalid = 1; s_readdata = 32'h77;
      #1;
      n_cmp++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL lock_rsp: got rdv=%b%b want m0", m1_readdatavalid, m0_readdatavalid); end
      next();
      idle();
   endtask

   task automatic test_single_read();
      m0_read = 1; m0_address = 32'h100;
      #1;
      n_cmp++; if (s_address !== 32'h100 || s_read !== 1'b1 || m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL single_cmd: got a=%h rd=%b w=%b want 100 1 0", s_address, s_read, m0_waitrequest); end
      next();
      idle();
      s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
      #1;
      n_cmp++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || err_unexp !== 1'b0) begin n_err++; $display("FAIL single_rsp: got rdv=%b%b err=%b want 01 0", m1_readdatavalid, m0_readdatavalid, err_unexp); end
      n_cmp++; if (m0_readdata !== 32'hDEADBEEF || m1_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h %h want deadbeef", m0_readdata, m1_readdata); end
      next();
      idle();
   endtask

   task automatic test_throttle();
      for (int i = 0; i < 4; i++) begin
         m0_read = 1; m0_address = 32'h800 + 32'(i * 4);
         #1;
         n_cmp++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL thr_fill%0d: got rd=%b w=%b want 1 0", i, s_read, m0_waitrequest); end
         next();
      end
      m1_write = 1; m1_address = 32'h500; s_readdatavalid = 1;
      #1;
      n_cmp++; if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin n_err++; $display("FAIL thr_block: got w=%b rd=%b want 1 0", m0_waitrequest, s_read); end
      n_cmp++; if (s_write !== 1'b1 || s_address !== 32'h500 || m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL thr_write: got wr=%b a=%h w=%b want 1 500 0", s_write, s_address, m1_waitrequest); end
      n_cmp++; if (m0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL thr_pop: got %b want 1", m0_readdatavalid); end
      next();
      m1_write = 0; s_readdatavalid = 0;
      #1;
      n_cmp++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 32'h80C) begin n_err++; $display("FAIL thr_issue: got rd=%b w=%b a=%h want 1 0 80c", s_read, m0_waitrequest, s_address); end
      next();
      idle();
      for (int i = 0; i < 4; i++) begin
         s_readdatavalid = 1;
         #1;
         n_cmp++; if (m0_readdatavalid !== 1'b1 || err_unexp !== 1'b0) begin n_err++; $display("FAIL thr_drain%0d: got rdv=%b err=%b want 1 0", i, m0_readdatavalid, err_unexp); end
         next();
      end
      idle();
   endtask

   task automatic test_unexpected();
      s_readdatavalid = 1;
      #1;
      n_cmp++; if (err_unexp !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL unexp_err: got err=%b rdv=%b%b want 1 00", err_unexp, m1_readdatavalid, m0_readdatavalid); end
      next();
      s_readdatavalid = 0;
      #1;
      n_cmp++; if (err_unexp !== 1'b0) begin n_err++; $display("FAIL unexp_pulse: got %b want 0", err_unexp); end
      m0_read = 1;
      next();
      m0_read = 0; m1_read = 1;
      #1;
      n_cmp++; if (s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL unexp_setup: got rd=%b w=%b want 1 0", s_read, m1_waitrequest); end
      next();
      idle();
      rest = 1;
      next();
      rest = 0;
      for (int i = 0; i < 2; i++) begin
         s_readdatavalid = 1;
         #1;
         n_cmp++; if (err_unexp !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL unexp_discard%0d: got err=%b rdv=%b%b want 1 00", i, err_unexp, m1_readdatavalid, m0_readdatavalid); end
         next();
      end
      idle();
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      test_reset();
      test_round_robin();
      test_lock();
      test_single_read();
      test_throttle();
      test_unexpected();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/core_bus_arb.md
CORE_BUS_ARB -- requirements
Module: core_bus_arb

Interface
REQ-001 Parameter MAX_PEND, default 4, meaning: depth of the read-response routing FIFO; SHALL be a power of 2 and at least 2.
REQ-002 Parameter RR_EN, default 1, meaning: 1 selects round-robin arbitration, 0 selects fixed priority with m1 winning.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rest  input  1  reset, asynchronous and active-high.
REQ-005 m0_address, m1_address  input  32  master address (m0 = instruction fetch, m1 = data access).
REQ-006 m0_read/m0_write, m1_read/m1_write  input  1 each  command strobes.
REQ-007 m0_writedata, m1_writedata  input  32; m0_byteenable, m1_byteenable  input  4.
REQ-008 m0_waitrequest, m1_waitrequest  output  1  command stall.
REQ-009 m0_readdata, m1_readdata  output  32; m0_readdatavalid, m1_readdatavalid  output  1.
REQ-010 s_address  output  32; s_read, s_write  output  1; s_writedata  output  32; s_byteenable  output  4  shared slave command.
REQ-011 s_waitrequest  input  1; s_readdata  input  32; s_readdatavalid  input  1  slave stall and in-order read response.
REQ-012 err_unexp  output  1  one-cycle pulse: read response arrived with no pending read.

Function
REQ-013 Request: mX_read or mX_write high; a simultaneous read and write from one master SHALL be treated as a write.
REQ-014 Acceptance: a command is accepted when s_read or s_write is high and s_waitrequest is low.
REQ-015 Lock: when the command driven to the slave is not accepted, the arbiter SHALL keep the same owner next cycle (state LOCKED); otherwise it SHALL return to state OPEN.
REQ-016 OPEN, one requester: it SHALL be granted in the same cycle (zero-latency combinational forwarding).
REQ-017 OPEN, both requesting, RR_EN=1: the master not granted at the last acceptance SHALL win; after reset, m0 SHALL win the first tie.
REQ-018 OPEN, both requesting, RR_EN=0: m1 SHALL win.
REQ-019 Granted master: s_address, s_writedata, s_byteenable, s_read and s_write SHALL equal its signals; mX_waitrequest SHALL equal s_waitrequest.
REQ-020 Non-granted requesting master: waitrequest SHALL be 1.
REQ-021 No grant: s_read and s_write SHALL be 0; s_address, s_writedata and s_byteenable SHALL be 0.
REQ-022 Read throttle: when the pending count equals MAX_PEND, any read SHALL be withheld from the slave with waitrequest=1, even if a pop occurs in the same cycle; writes are unaffected.
REQ-023 A throttled read SHALL not block a write from the other master; in OPEN the write SHALL be granted.
REQ-024 An accepted read SHALL push its owner ID into the FIFO; the count SHALL increment.
REQ-025 s_readdatavalid SHALL pop the FIFO head and assert that owner's readdatavalid in the same cycle; the count SHALL decrement.
REQ-026 s_readdata SHALL be broadcast to both mX_readdata.
REQ-027 A simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo MAX_PEND.
REQ-028 s_readdatavalid with an empty FIFO SHALL assert err_unexp for one cycle, assert no mX_readdatavalid, and leave the count at 0.
REQ-029 Reads from both masters SHALL be routed correctly when the grant changes while reads are outstanding.

Reset
REQ-030 While rest=1: s_read=s_write=0, m0/m1_waitrequest=1, m0/m1_readdatavalid=0, err_unexp=0, state=OPEN, FIFO empty, RR pointer set so m0 wins the next tie.
REQ-031 Reset mid-operation SHALL discard all pending reads; their later responses SHALL be handled per REQ-028.

Verification
REQ-032 m0_read only, s_waitrequest=0, A=0x100 -> s_address=0x100 and s_read=1 in the same cycle; response 0xDEADBEEF -> m0_readdatavalid=1, m1_readdatavalid=0.
REQ-033 Both read continuously, RR_EN=1, no stalls -> grants alternate m0,m1,m0,m1; responses route to the matching masters in order.
REQ-034 m1_write stalled 3 cycles by s_waitrequest while m0_read is pending -> m1 remains owner for all 4 cycles, m0_waitrequest=1 throughout, m0 granted in cycle 5.
REQ-035 MAX_PEND=4, 4 accepted reads, no responses -> fifth read sees waitrequest=1 and s_read=0; a concurrent m1_write is accepted; after one response the read is issued next cycle.
REQ-036 s_readdatavalid pulsed with no pending reads, and rest pulsed with 2 reads pending followed by 2 responses -> err_unexp pulses 1 then 2 times, no mX_readdatavalid.
